// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the CPU memory-port arbiter.
// Widths default to the values used by the Fetch and Memory stages.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W     = 16;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_STARVE_MAX = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    // Bits needed to hold a saturating count of 0..max_val
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) <= 64'(max_val)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/arb_starve_pick.sv
// Priority pick between fetch and data requests, with a starvation counter
// that forces a fetch win after STARVE_MAX consecutive data wins.
module arb_starve_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic if_req,
    input  logic dm_req,
    output logic pick_if_c,
    output logic pick_dm_c
);

    localparam int unsigned      CNT_W   = cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    // Data wins unless fetch has been passed over STARVE_MAX times in a row
    always_comb begin
        starve_hit = if_req && (starve_cnt == CNT_MAX);
        pick_dm_c  = arb_en && dm_req && !starve_hit;
        pick_if_c  = arb_en && if_req && !pick_dm_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!if_req || pick_if_c) begin
            starve_cnt <= '0;
        end else if (pick_dm_c && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the memory stage,
// tracking one outstanding transaction and routing its response to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              flush,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    logic   drop_if_q, drop_if_d;

    logic              arb_en;
    logic              if_req_eff;
    logic              dm_req_eff;
    logic              pick_if_c;
    logic              pick_dm_c;

    logic              if_gnt_d, dm_gnt_d, if_rvalid_d, dm_rvalid_d;
    logic [DATA_W-1:0] if_rdata_d, dm_rdata_d;
    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    // A request is still visible during its own grant cycle; mask it so an
    // immediate ack cannot grant the same request twice.
    always_comb begin
        if_req_eff = if_req && !if_gnt;
        dm_req_eff = dm_req && !dm_gnt;
        arb_en     = (state_q == ST_IDLE) || ((state_q == ST_BUSY) && mem_ack);
    end

    arb_starve_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk       (clk),
        .rst       (rst),
        .arb_en    (arb_en),
        .if_req    (if_req_eff),
        .dm_req    (dm_req_eff),
        .pick_if_c (pick_if_c),
        .pick_dm_c (pick_dm_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            drop_if_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            drop_if_q <= drop_if_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_if_d   = drop_if_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state_q)
            ST_IDLE: begin
                owner_d   = OWN_NONE;
                drop_if_d = 1'b0;
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    // Retire the current op; a pick below may start the next one
                    drop_if_d   = 1'b0;
                    state_d     = ST_IDLE;
                    owner_d     = OWN_NONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if ((owner_q == OWN_IF) && !drop_if_q && !flush) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                    if (owner_q == OWN_DM) begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = mem_we ? '0 : mem_rdata;
                    end
                end else if (flush && (owner_q == OWN_IF)) begin
                    drop_if_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        if (pick_dm_c) begin
            dm_gnt_d    = 1'b1;
            state_d     = ST_BUSY;
            owner_d     = OWN_DM;
            mem_req_d   = 1'b1;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
        end else if (pick_if_c) begin
            if_gnt_d    = 1'b1;
            state_d     = ST_BUSY;
            owner_d     = OWN_IF;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_gnt    <= if_gnt_d;
            dm_gnt    <= dm_gnt_d;
            if_rvalid <= if_rvalid_d;
            dm_rvalid <= dm_rvalid_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset, single read,
// contention, starvation, flush and write.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          flush;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .flush     (flush),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #2 rst = 1'b0;
        step(); step();
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_if_gnt",    32'(if_gnt),    32'd0);
        check("rst_dm_gnt",    32'(dm_gnt),    32'd0);
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
        rst = 1'b1;
        step();
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

        // Single fetch read, ack three cycles after the grant
        if_req = 1'b1; if_addr = 16'h0010;
        step();
        check("t2_if_gnt",   32'(if_gnt),   32'd1);
        check("t2_dm_gnt",   32'(dm_gnt),   32'd0);
        check("t2_mem_req",  32'(mem_req),  32'd1);
        check("t2_mem_addr", 32'(mem_addr), 32'h0010);
        check("t2_mem_we",   32'(mem_we),   32'd0);
        if_req = 1'b0;
        step();
        check("t2_gnt_pulse", 32'(if_gnt),  32'd0);
        check("t2_mem_hold",  32'(mem_req), 32'd1);
        step();
        mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        step();
        mem_ack = 1'b0;
        check("t2_if_rvalid", 32'(if_rvalid), 32'd1);
        check("t2_if_rdata",  32'(if_rdata),  32'hA5A5);
        check("t2_dm_rvalid", 32'(dm_rvalid), 32'd0);
        check("t2_mem_drop",  32'(mem_req),   32'd0);
        step();
        check("t2_rvalid_pulse", 32'(if_rvalid), 32'd0);

        // Contention: data first, fetch granted on the data ack edge
        if_req = 1'b1; if_addr = 16'h0020;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200;
        step();
        check("t3_dm_gnt",   32'(dm_gnt),   32'd1);
        check("t3_if_gnt",   32'(if_gnt),   32'd0);
        check("t3_mem_addr", 32'(mem_addr), 32'h0200);
        dm_req = 1'b0;
        step();
        check("t3_if_wait", 32'(if_gnt), 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        step();
        mem_ack = 1'b0; if_req = 1'b0;
        check("t3_dm_rvalid", 32'(dm_rvalid), 32'd1);
        check("t3_dm_rdata",  32'(dm_rdata),  32'h5555);
        check("t3_if_gnt2",   32'(if_gnt),    32'd1);
        check("t3_no_gap",    32'(mem_req),   32'd1);
        check("t3_mem_addr2", 32'(mem_addr),  32'h0020);
        step();
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0;
        check("t3_if_rvalid", 32'(if_rvalid), 32'd1);
        check("t3_if_rdata",  32'(if_rdata),  32'h1111);
        check("t3_mem_drop",  32'(mem_req),   32'd0);

        // Starvation: four data wins, then fetch is forced through
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0400;
        if_req = 1'b1; if_addr = 16'h0040;
        step();
        for (int g = 0; g < 5; g++) begin
            check("t4_dm_gnt",  32'(dm_gnt), 32'(g < 4));
            check("t4_if_gnt",  32'(if_gnt), 32'(g == 4));
            check("t4_starve",  32'(dut.u_pick.starve_cnt), (g < 4) ? 32'(g + 1) : 32'd0);
            if (g > 0) begin
                check("t4_dm_rvalid", 32'(dm_rvalid), 32'd1);
                check("t4_dm_rdata",  32'(dm_rdata),  32'(g - 1));
            end
            if (g < 4) begin
                step();
                mem_ack = 1'b1; mem_rdata = 16'(g);
                step();
                mem_ack = 1'b0;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hC0DE;
        step();
        mem_ack = 1'b0;
        check("t4_if_rvalid", 32'(if_rvalid), 32'd1);
        check("t4_if_rdata",  32'(if_rdata),  32'hC0DE);
        check("t4_mem_drop",  32'(mem_req),   32'd0);

        // Flush while the fetch is in flight drops its response
        if_req = 1'b1; if_addr = 16'h0050;
        step();
        check("t5_if_gnt", 32'(if_gnt), 32'd1);
        if_req = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        check("t5_rvalid_drop", 32'(if_rvalid), 32'd0);
        check("t5_mem_drop",    32'(mem_req),   32'd0);
        if_req = 1'b1; if_addr = 16'h0060;
        step();
        check("t5_next_gnt", 32'(if_gnt),   32'd1);
        check("t5_next_adr", 32'(mem_addr), 32'h0060);
        if_req = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        step();
        mem_ack = 1'b0;
        check("t5_next_rvalid", 32'(if_rvalid), 32'd1);
        check("t5_next_rdata",  32'(if_rdata),  32'h7777);

        // Flush on the ack cycle also drops the response
        if_req = 1'b1; if_addr = 16'h0070;
        step();
        if_req = 1'b0;
        mem_ack = 1'b1; flush = 1'b1; mem_rdata = 16'h9999;
        step();
        mem_ack = 1'b0; flush = 1'b0;
        check("t5_ack_flush", 32'(if_rvalid), 32'd0);
        check("t5_ack_drop",  32'(mem_req),   32'd0);

        // Data write: immediate ack, rdata reads back as zero
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'h1234;
        step();
        check("t6_dm_gnt",    32'(dm_gnt),    32'd1);
        check("t6_mem_we",    32'(mem_we),    32'd1);
        check("t6_mem_addr",  32'(mem_addr),  32'h0300);
        check("t6_mem_wdata", 32'(mem_wdata), 32'h1234);
        dm_req = 1'b0; dm_we = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        step();
        mem_ack = 1'b0;
        check("t6_dm_rvalid", 32'(dm_rvalid), 32'd1);
        check("t6_dm_rdata",  32'(dm_rdata),  32'd0);
        check("t6_if_rvalid", 32'(if_rvalid), 32'd0);
        check("t6_mem_drop",  32'(mem_req),   32'd0);

        // Reset landing mid-transaction clears outputs without a clock edge
        dm_req = 1'b1; dm_addr = 16'h0500;
        step();
        check("t1_busy_req", 32'(mem_req), 32'd1);
        check("t1_busy_gnt", 32'(dm_gnt),  32'd1);
        dm_req = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t1_mem_req",   32'(mem_req),   32'd0);
        check("t1_dm_gnt",    32'(dm_gnt),    32'd0);
        check("t1_if_gnt",    32'(if_gnt),    32'd0);
        check("t1_if_rvalid", 32'(if_rvalid), 32'd0);
        check("t1_dm_rvalid", 32'(dm_rvalid), 32'd0);
        check("t1_mem_addr",  32'(mem_addr),  32'd0);
        step();
        rst = 1'b1;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("t1_idle_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("t1_ack_ignored", 32'(dm_rvalid), 32'd0);
        check("t1_idle_req",    32'(mem_req),   32'd0);
        if_req = 1'b1; if_addr = 16'h0080;
        step();
        if_req = 1'b0;
        check("t1_post_gnt",  32'(if_gnt),   32'd1);
        check("t1_post_addr", 32'(mem_addr), 32'h0080);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
